// File: rtl/rle_line_scheduler.sv
// Scanline scheduler: walks R, G, B of one line through a shared RLE engine
// and queues the tagged run records in a first-word fall-through FIFO.
module rle_line_scheduler #(
    parameter int ChannelLength = 640,
    parameter int Lines         = 480,
    parameter int MaxRunLength  = 12,
    parameter int FifoDepth     = 16,
    localparam int XW = $clog2(ChannelLength),
    localparam int LW = $clog2(Lines),
    localparam int RW = 2 + LW + XW + MaxRunLength + 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_line_valid,
    input  logic [LW-1:0]           i_line_idx,
    output logic                    o_line_done,
    output logic                    o_rd_en,
    output logic [XW-1:0]           o_rd_addr,
    input  logic [23:0]             i_rd_curr,
    input  logic [23:0]             i_rd_prev,
    output logic                    o_eng_rst_n,
    output logic                    o_eng_ready,
    output logic [7:0]              o_eng_curr,
    output logic [7:0]              o_eng_prev,
    input  logic                    i_eng_busy,
    input  logic                    i_eng_ready,
    input  logic [7:0]              i_eng_val,
    input  logic [MaxRunLength-1:0] i_eng_count,
    input  logic [XW-1:0]           i_eng_start_x,
    output logic [RW-1:0]           o_rec_data,
    output logic                    o_rec_valid,
    input  logic                    i_rec_ready,
    output logic                    o_overflow
);

    localparam int AW = $clog2(FifoDepth);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENG_RST,
        S_READ,
        S_WAIT_RD,
        S_FEED,
        S_WAIT_ENG,
        S_NEXT_CH,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      ch_q, ch_d;
    logic [XW-1:0]   x_q, x_d;
    logic [LW-1:0]   line_q, line_d;
    logic [7:0]      curr_q, curr_d;
    logic [7:0]      prev_q, prev_d;

    logic [RW-1:0]   mem_q [FifoDepth];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            free_ok;
    logic [CW-1:0]   free;
    logic [RW-1:0]   rec_in;

    function automatic logic [7:0] sel_byte(
        input logic [23:0] px,
        input logic [1:0]  ch
    );
        logic [7:0] b;
        unique case (ch)
            2'd0:    b = px[23:16];
            2'd1:    b = px[15:8];
            default: b = px[7:0];
        endcase
        return b;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(FifoDepth));
    assign free    = CW'(FifoDepth) - cnt_q;
    // Two free slots cover the record the engine may still emit for the
    // pixel in flight plus the one this read can produce.
    assign free_ok = (free >= CW'(2));
    assign pop     = !empty && i_rec_ready;
    assign push    = i_eng_ready && (!full || pop);
    assign rec_in  = {ch_q, line_q, i_eng_start_x, i_eng_count, i_eng_val};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (i_eng_ready && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        x_d     = x_q;
        line_d  = line_q;
        curr_d  = curr_q;
        prev_d  = prev_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_line_valid) begin
                    line_d  = i_line_idx;
                    ch_d    = 2'd0;
                    state_d = S_ENG_RST;
                end
            end
            S_ENG_RST: begin
                x_d     = '0;
                state_d = S_READ;
            end
            S_READ: begin
                if (free_ok) begin
                    state_d = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                curr_d  = sel_byte(i_rd_curr, ch_q);
                prev_d  = sel_byte(i_rd_prev, ch_q);
                state_d = S_FEED;
            end
            S_FEED: begin
                if (!i_eng_busy) begin
                    state_d = S_WAIT_ENG;
                end
            end
            S_WAIT_ENG: begin
                if (!i_eng_busy) begin
                    if (x_q == XW'(ChannelLength - 1)) begin
                        state_d = S_NEXT_CH;
                    end else begin
                        x_d     = x_q + XW'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_NEXT_CH: begin
                if (ch_q == 2'd2) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    state_d = S_ENG_RST;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            x_q      <= '0;
            line_q   <= '0;
            curr_q   <= '0;
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            x_q      <= x_d;
            line_q   <= line_d;
            curr_q   <= curr_d;
            prev_q   <= prev_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Record storage carries no reset; validity is tracked by cnt_q.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem_q[wr_ptr_q] <= rec_in;
        end
    end

    assign o_line_done = !RST && (state_q == S_DONE);
    assign o_rd_en     = !RST && (state_q == S_READ) && free_ok;
    assign o_rd_addr   = x_q;
    assign o_eng_rst_n = !RST && (state_q != S_ENG_RST);
    assign o_eng_ready = !RST && (state_q == S_FEED) && !i_eng_busy;
    assign o_eng_curr  = curr_q;
    assign o_eng_prev  = prev_q;
    assign o_rec_valid = !empty;
    assign o_rec_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign o_overflow  = ovf_q;

endmodule
